// File: rtl/param_sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo_if
// Description : Handshake, data and status bundle for param_sync_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                     w_en;
    logic                     r_en;
    logic [DATA_WIDTH-1:0]    data_in;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output w_en, r_en, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, data_in,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_sync_fifo
// Description : Single-clock FIFO with occupancy flags and sticky error flags.
//               Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  wire                 clk,
    input  wire                 rst,
    param_sync_fifo_if.slave    bus
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_AE_CNT   = c_CNT_W'(AE_LEVEL);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_CNT_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_ADDR_W-1:0]   w_wr_addr;
    logic [c_ADDR_W-1:0]   w_rd_addr;

    // Flags come only from registered state, so requests never reach them.
    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_wr_acc  = bus.w_en && !w_full;
    assign w_rd_acc  = bus.r_en && !w_empty;
    assign w_wr_addr = r_wr_ptr[c_ADDR_W-1:0];
    assign w_rd_addr = r_rd_ptr[c_ADDR_W-1:0];

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[w_wr_addr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_ONE;
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_ONE;
            end
            if (bus.w_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.r_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    // Head entry falls through; forced to zero so unwritten storage never shows.
    assign bus.data_out = w_empty ? '0 : r_mem[w_rd_addr];
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[w_rd_addr];
        end
    end

    assign bus.data_out = r_data_out;
`endif

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= c_AF_CNT);
    assign bus.almost_empty = (r_count <= c_AE_CNT);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_sync_fifo
// Description : Directed and random stimulus against a queue-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_sync_fifo;
    localparam int c_DW    = 8;
    localparam int c_DEPTH = 16;
    localparam int c_AF    = 14;
    localparam int c_AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    param_sync_fifo_if #(.DATA_WIDTH(c_DW), .DEPTH(c_DEPTH)) bus ();

    param_sync_fifo #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .AF_LEVEL   (c_AF),
        .AE_LEVEL   (c_AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain queue plus sticky flags and last-read word.
    logic [c_DW-1:0] m_q[$];
    logic            m_of;
    logic            m_uf;
    logic [c_DW-1:0] m_dout;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        logic [c_DW-1:0] exp_dout;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        exp_dout = (m_q.size() != 0) ? m_q[0] : '0;
`else
        exp_dout = m_dout;
`endif
        check("count",        32'(bus.count),        32'(m_q.size()));
        check("full",         32'(bus.full),         32'(m_q.size() == c_DEPTH));
        check("empty",        32'(bus.empty),        32'(m_q.size() == 0));
        check("almost_full",  32'(bus.almost_full),  32'(m_q.size() >= c_AF));
        check("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= c_AE));
        check("overflow",     32'(bus.overflow),     32'(m_of));
        check("underflow",    32'(bus.underflow),    32'(m_uf));
        check("data_out",     32'(bus.data_out),     32'(exp_dout));
    endtask

    // One clock: drive, advance model from pre-edge occupancy, sample 1 time unit later.
    task automatic step(input logic w, input logic r, input logic [c_DW-1:0] d, input logic rs);
        bit was_full;
        bit was_empty;
        bus.w_en    = w;
        bus.r_en    = r;
        bus.data_in = d;
        rst         = rs;
        @(posedge clk);
        if (rs) begin
            m_q.delete();
            m_of   = 1'b0;
            m_uf   = 1'b0;
            m_dout = '0;
        end else begin
            was_full  = (m_q.size() == c_DEPTH);
            was_empty = (m_q.size() == 0);
            if (w && was_full)  m_of = 1'b1;
            if (r && was_empty) m_uf = 1'b1;
            if (r && !was_empty) m_dout = m_q.pop_front();
            if (w && !was_full)  m_q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        m_of   = 1'b0;
        m_uf   = 1'b0;
        m_dout = '0;

        // Reset state, with a request pending to show reset priority
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Fill with 0x00..0x0F then drain in order
        for (int i = 0; i < c_DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        check("fill_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < c_DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        check("drain_last", 32'(bus.data_out), 32'h0F);

        // Write while full with simultaneous read: read only
        for (int i = 0; i < c_DEPTH; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        check("wr_full_count", 32'(bus.count), 32'd15);
        check("wr_full_of",    32'(bus.overflow), 32'd1);
        for (int i = 0; i < c_DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Read while empty with simultaneous write: write only
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        check("rd_empty_count", 32'(bus.count), 32'd1);
        check("rd_empty_uf",    32'(bus.underflow), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("rd_after_uf", 32'(bus.data_out), 32'h55);

        // Interleaved traffic that wraps both pointers
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'(i % 2), 8'($urandom), 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Reset in the middle of a write stream
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        step(1'b1, 1'b0, 8'hC5, 1'b1);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Single word, idle, then pop (fall-through visibility in FWFT builds)
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("single_empty", 32'(bus.empty), 32'd1);

        // Random traffic: write-heavy then read-heavy, with rare resets
        for (int i = 0; i < 400; i++) begin
            int wp;
            int rp;
            wp = (i < 200) ? 70 : 30;
            rp = (i < 200) ? 35 : 75;
            step(1'($urandom_range(99) < wp), 1'($urandom_range(99) < rp),
                 8'($urandom), 1'($urandom_range(99) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
